if_align: RTL

Instruction-fetch realignment stage between the icache and decode. It accepts 32-bit word-aligned fetch responses and buffers them as halfwords. It then emits whole RV instructions, 16-bit compressed or 32-bit, including 32-bit instructions that straddle two fetch words, each tagged with its PC and a compressed flag. Its `is_compressed_o` output is the source of the PC generator's compressed-instruction input, and `flush_i`/`redirect_pc_i` share the same trap/branch redirect that steers the PC generator.

---
 rtl/if_align_pkg.sv | 14 +
 rtl/if_align_queue.sv | 55 +++++
 rtl/if_align.sv | 94 +++++++++
 3 files changed

// File: rtl/if_align_pkg.sv
// Shared constants and helpers for the instruction-fetch realignment stage.
package if_align_pkg;

  localparam int unsigned XLEN_DEF          = 32;
  localparam logic [31:0] PC_RESET_ADDR_DEF = 32'h8000_0000;
  localparam int unsigned IF_HW_DEPTH       = 4;
  localparam logic [1:0]  RVC_LEN_MASK      = 2'b11;

  // A halfword starts a compressed instruction unless both low bits are set.
  function automatic logic is_rvc(input logic [15:0] hw);
    return (hw[1:0] & RVC_LEN_MASK) != RVC_LEN_MASK;
  endfunction

endpackage

// File: rtl/if_align_queue.sv
// Four-entry halfword shift queue; entry 0 is the head. Supports push of 0/1/2
// halfwords and pop of 0/1/2 halfwords in the same cycle, plus a synchronous clear.
module if_align_queue
  import if_align_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic [1:0]  push_cnt_i,
  input  logic [31:0] push_data_i,
  input  logic [1:0]  pop_cnt_i,
  output logic [15:0] hw0_o,
  output logic [15:0] hw1_o,
  output logic [2:0]  count_o
);

  logic [15:0] r_q [IF_HW_DEPTH];
  logic [2:0]  r_count;
  logic [15:0] w_q_d [IF_HW_DEPTH];
  logic [2:0]  w_count_d;
  logic [2:0]  w_base;

  // Pop shifts the survivors down first; pushes then land just above them.
  always_comb begin
    w_base = r_count - {1'b0, pop_cnt_i};
    for (int i = 0; i < int'(IF_HW_DEPTH); i++) begin
      w_q_d[i] = '0;
      for (int j = 0; j < int'(IF_HW_DEPTH); j++) begin
        if (j == i + int'(pop_cnt_i)) w_q_d[i] = r_q[j];
      end
      if (push_cnt_i != 2'd0 && i == int'(w_base))     w_q_d[i] = push_data_i[15:0];
      if (push_cnt_i == 2'd2 && i == int'(w_base) + 1) w_q_d[i] = push_data_i[31:16];
    end
    w_count_d = w_base + {1'b0, push_cnt_i};
    if (clear_i) begin
      for (int i = 0; i < int'(IF_HW_DEPTH); i++) w_q_d[i] = '0;
      w_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(IF_HW_DEPTH); i++) r_q[i] <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(IF_HW_DEPTH); i++) r_q[i] <= w_q_d[i];
      r_count <= w_count_d;
    end
  end

  assign hw0_o   = r_q[0];
  assign hw1_o   = r_q[1];
  assign count_o = r_count;

endmodule

// File: rtl/if_align.sv
// Realigns word-aligned icache responses into whole 16/32-bit RV instructions
// tagged with their PC, including 32-bit instructions straddling two fetch words.
module if_align
  import if_align_pkg::*;
#(
  parameter int unsigned     XLEN          = XLEN_DEF,
  parameter logic [XLEN-1:0] PC_RESET_ADDR = XLEN'(PC_RESET_ADDR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            icache_valid_i,
  input  logic [31:0]     icache_data_i,
  input  logic [XLEN-1:0] icache_pc_i,
  output logic            icache_ready_o,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            is_compressed_o
);

  logic [XLEN-1:0] r_head_pc;
  logic [XLEN-1:0] r_expect_pc;
  logic            r_drop_low;

  logic [15:0] w_hw0;
  logic [15:0] w_hw1;
  logic [2:0]  w_count;
  logic        w_is_c;
  logic        w_dec_valid;
  logic        w_word_use;
  logic        w_consume;
  logic [1:0]  w_push_cnt;
  logic [31:0] w_push_data;
  logic [1:0]  w_pop_cnt;

  if_align_queue u_queue (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (flush_i),
    .push_cnt_i  (w_push_cnt),
    .push_data_i (w_push_data),
    .pop_cnt_i   (w_pop_cnt),
    .hw0_o       (w_hw0),
    .hw1_o       (w_hw1),
    .count_o     (w_count)
  );

  always_comb begin
    w_is_c      = is_rvc(w_hw0);
    w_dec_valid = w_is_c ? (w_count >= 3'd1) : (w_count >= 3'd2);
  end

  // Ready comes from registered occupancy only, so decode backpressure never
  // reaches the icache combinationally.
  assign icache_ready_o  = (w_count <= 3'd2);
  assign inst_valid_o    = w_dec_valid & ~flush_i;
  assign is_compressed_o = w_dec_valid & w_is_c;
  assign inst_pc_o       = r_head_pc;

  always_comb begin
    inst_o = '0;
    if (w_dec_valid) inst_o = w_is_c ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
  end

  // Stale words (wrong address) are still consumed but push nothing.
  assign w_word_use  = icache_valid_i & icache_ready_o & ~flush_i &
                       (icache_pc_i == r_expect_pc);
  assign w_consume   = inst_valid_o & inst_ready_i;
  assign w_push_cnt  = w_word_use ? (r_drop_low ? 2'd1 : 2'd2) : 2'd0;
  assign w_push_data = r_drop_low ? {16'h0000, icache_data_i[31:16]} : icache_data_i;
  assign w_pop_cnt   = w_consume ? (w_is_c ? 2'd1 : 2'd2) : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_pc   <= PC_RESET_ADDR;
      r_expect_pc <= PC_RESET_ADDR;
      r_drop_low  <= 1'b0;
    end else if (flush_i) begin
      r_head_pc   <= redirect_pc_i;
      r_expect_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      r_drop_low  <= redirect_pc_i[1];
    end else begin
      if (w_consume) r_head_pc <= r_head_pc + (w_is_c ? XLEN'(2) : XLEN'(4));
      if (w_word_use) begin
        r_expect_pc <= r_expect_pc + XLEN'(4);
        r_drop_low  <= 1'b0;
      end
    end
  end

endmodule
